// File: rtl/multi_function_register_bank_pkg.sv
// reg_bank_pkg
//   Shared definitions for the multi-function register bank: the 4-bit
//   function-select encoding applied to every enabled register cell.
package reg_bank_pkg;

   typedef enum logic [3:0] {
      FS_DEC      = 4'b0000,  // Q-1, wraps, sets wrap flag on 0 -> all-ones
      FS_INC      = 4'b0001,  // Q+1, wraps, sets wrap flag on all-ones -> 0
      FS_LOAD     = 4'b0010,  // Q = I
      FS_CLEAR    = 4'b0011,  // Q = 0, wrap flag cleared
      FS_LO_ZEXT  = 4'b0100,  // Q = zero-extended low half of I
      FS_LO_LOAD  = 4'b0101,  // low half of Q from low half of I
      FS_HI_LOAD  = 4'b0110,  // high half of Q from low half of I
      FS_LO_SEXT  = 4'b0111,  // Q = sign-extended low half of I
      FS_SLL      = 4'b1000,
      FS_SRL      = 4'b1001,
      FS_SRA      = 4'b1010,
      FS_ROL      = 4'b1011,
      FS_ROR      = 4'b1100,
      FS_SAT_INC  = 4'b1101,  // stops at all-ones, never touches wrap flag
      FS_SAT_DEC  = 4'b1110,  // stops at zero, never touches wrap flag
      FS_HOLD     = 4'b1111
   } fun_sel_e;

endpackage

// File: rtl/multi_function_register_bank_reg_cell.sv
// reg_cell
//   One register of the bank plus its sticky wrap flag and function decode.
// Ports:
//   Clock   in  1      rising-edge clock
//   Reset   in  1      synchronous active-high reset
//   en      in  1      update enable for this cell
//   FunSel  in  4      function select (reg_bank_pkg::fun_sel_e encoding)
//   I       in  WIDTH  write data
//   Q       out WIDTH  current register value
//   Wrap    out 1      sticky wrap flag
module reg_cell
   import reg_bank_pkg::*;
#(
   parameter int                WIDTH       = 16,
   parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              en,
   input  logic [3:0]        FunSel,
   input  logic [WIDTH-1:0]  I,
   output logic [WIDTH-1:0]  Q,
   output logic              Wrap
);

   localparam int HALF = WIDTH / 2;
   localparam logic [WIDTH-1:0] ALL_ONES = '1;
   localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

   logic [WIDTH-1:0] q_reg, q_next;
   logic             wrap_reg, wrap_next;

   always_comb begin
      q_next    = q_reg;
      wrap_next = wrap_reg;
      case (FunSel)
         FS_DEC: begin
            q_next = q_reg - ONE;
            if (q_reg == '0) wrap_next = 1'b1;
         end
         FS_INC: begin
            q_next = q_reg + ONE;
            if (q_reg == ALL_ONES) wrap_next = 1'b1;
         end
         FS_LOAD:    q_next = I;
         FS_CLEAR: begin
            q_next    = '0;
            wrap_next = 1'b0;
         end
         FS_LO_ZEXT: q_next = {{HALF{1'b0}}, I[HALF-1:0]};
         FS_LO_LOAD: q_next[HALF-1:0] = I[HALF-1:0];
         // The high half is loaded from the LOW half of I so that byte-wide
         // sources can fill either half without a separate shifter upstream.
         FS_HI_LOAD: q_next[WIDTH-1:HALF] = I[HALF-1:0];
         FS_LO_SEXT: q_next = {{HALF{I[HALF-1]}}, I[HALF-1:0]};
         FS_SLL:     q_next = {q_reg[WIDTH-2:0], 1'b0};
         FS_SRL:     q_next = {1'b0, q_reg[WIDTH-1:1]};
         FS_SRA:     q_next = {q_reg[WIDTH-1], q_reg[WIDTH-1:1]};
         FS_ROL:     q_next = {q_reg[WIDTH-2:0], q_reg[WIDTH-1]};
         FS_ROR:     q_next = {q_reg[0], q_reg[WIDTH-1:1]};
         FS_SAT_INC: if (q_reg != ALL_ONES) q_next = q_reg + ONE;
         FS_SAT_DEC: if (q_reg != '0)       q_next = q_reg - ONE;
         default: begin
            q_next    = q_reg;
            wrap_next = wrap_reg;
         end
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         q_reg    <= RESET_VALUE;
         wrap_reg <= 1'b0;
      end else if (en) begin
         q_reg    <= q_next;
         wrap_reg <= wrap_next;
      end
   end

   assign Q    = q_reg;
   assign Wrap = wrap_reg;

endmodule

// File: rtl/multi_function_register_bank.sv
// multi_function_register_bank
//   Bank of NUM_REGS working registers feeding the ALU operand muxes. Every
//   enabled register applies the same FunSel/I to its own value; two
//   combinational read ports with a zero detect on port A.
// Ports:
//   Clock             in  1         rising-edge clock
//   Reset             in  1         synchronous active-high reset
//   I                 in  WIDTH     write data shared by all registers
//   E                 in  NUM_REGS  per-register enable
//   FunSel            in  4         function select
//   OutASel, OutBSel  in  SEL_W     read selects (out-of-range reads 0)
//   OutA, OutB        out WIDTH     read data (pre-edge register contents)
//   OutAZero          out 1         OutA == 0
//   Wrap              out NUM_REGS  sticky wrap flags
module multi_function_register_bank
   import reg_bank_pkg::*;
#(
   parameter int                WIDTH       = 16,
   parameter int                NUM_REGS    = 4,
   parameter int                SEL_W       = $clog2(NUM_REGS),
   parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
   input  logic                 Clock,
   input  logic                 Reset,
   input  logic [WIDTH-1:0]     I,
   input  logic [NUM_REGS-1:0]  E,
   input  logic [3:0]           FunSel,
   input  logic [SEL_W-1:0]     OutASel,
   input  logic [SEL_W-1:0]     OutBSel,
   output logic [WIDTH-1:0]     OutA,
   output logic [WIDTH-1:0]     OutB,
   output logic                 OutAZero,
   output logic [NUM_REGS-1:0]  Wrap
);

   logic [WIDTH-1:0] q_array [NUM_REGS];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REGS; gi++) begin : g_cell
         reg_cell #(
            .WIDTH       (WIDTH),
            .RESET_VALUE (RESET_VALUE)
         ) u_cell (
            .Clock  (Clock),
            .Reset  (Reset),
            .en     (E[gi]),
            .FunSel (FunSel),
            .I      (I),
            .Q      (q_array[gi]),
            .Wrap   (Wrap[gi])
         );
      end
   endgenerate

   // Compare-per-entry mux: any select value with no matching register
   // (non-power-of-two NUM_REGS) falls through to the zero default.
   always_comb begin
      OutA = '0;
      OutB = '0;
      for (int k = 0; k < NUM_REGS; k++) begin
         if (OutASel == SEL_W'(k)) OutA = q_array[k];
         if (OutBSel == SEL_W'(k)) OutB = q_array[k];
      end
   end

   assign OutAZero = (OutA == '0);

endmodule

// File: tb/tb_multi_function_register_bank.sv
module tb_multi_function_register_bank;
   import reg_bank_pkg::*;

   logic        Clock;
   logic        Reset;
   logic [15:0] I;
   logic [3:0]  E;
   logic [3:0]  FunSel;
   logic [1:0]  OutASel, OutBSel;
   logic [15:0] OutA, OutB;
   logic        OutAZero;
   logic [3:0]  Wrap;

   // Three-register instance sharing the same stimulus; port A is parked on
   // the out-of-range select 3.
   logic [2:0]  E3;
   logic [1:0]  OutASel3;
   logic [15:0] OutA3, OutB3;
   logic        OutAZero3;
   logic [2:0]  Wrap3;

   assign E3       = E[2:0];
   assign OutASel3 = 2'd3;

   multi_function_register_bank #(.WIDTH(16), .NUM_REGS(4), .RESET_VALUE(16'h0000)) dut (
      .Clock(Clock), .Reset(Reset), .I(I), .E(E), .FunSel(FunSel),
      .OutASel(OutASel), .OutBSel(OutBSel), .OutA(OutA), .OutB(OutB),
      .OutAZero(OutAZero), .Wrap(Wrap)
   );

   multi_function_register_bank #(.WIDTH(16), .NUM_REGS(3), .RESET_VALUE(16'h0000)) dut3 (
      .Clock(Clock), .Reset(Reset), .I(I), .E(E3), .FunSel(FunSel),
      .OutASel(OutASel3), .OutBSel(OutBSel), .OutA(OutA3), .OutB(OutB3),
      .OutAZero(OutAZero3), .Wrap(Wrap3)
   );

   initial begin
      Clock = 1'b0;
      forever #5 Clock = ~Clock;
   end

   typedef struct {
      string       name;
      logic [15:0] exp_a;
      logic [15:0] exp_b;
      logic [3:0]  exp_wrap;
      logic [15:0] exp_b3;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   bit   done   = 1'b0;

   // Issue one transaction before the next rising edge; the expected
   // post-edge view of the read ports is queued for the monitor.
   task automatic txn(input logic rst, input logic [3:0] e, input logic [3:0] fs,
                      input logic [15:0] din, input logic [1:0] asel, input logic [1:0] bsel,
                      input string name, input logic [15:0] ea, input logic [15:0] eb,
                      input logic [3:0] ew);
      exp_t x;
      @(negedge Clock);
      Reset   = rst;
      E       = e;
      FunSel  = fs;
      I       = din;
      OutASel = asel;
      OutBSel = bsel;
      x.name     = name;
      x.exp_a    = ea;
      x.exp_b    = eb;
      x.exp_wrap = ew;
      x.exp_b3   = (bsel == 2'd3) ? 16'h0000 : eb;
      sb.push_back(x);
   endtask

   // Monitor: one queued expectation per clock edge, compared 1 time unit
   // after the edge.
   initial begin
      exp_t x;
      forever begin
         @(posedge Clock);
         #1;
         if (sb.size() > 0) begin
            x = sb.pop_front();
            checks++;
            if (OutA !== x.exp_a || OutB !== x.exp_b || Wrap !== x.exp_wrap ||
                OutAZero !== (x.exp_a == 16'h0000) ||
                OutA3 !== 16'h0000 || OutAZero3 !== 1'b1 ||
                OutB3 !== x.exp_b3 || Wrap3 !== x.exp_wrap[2:0]) begin
               errors++;
               $display("FAIL %s: got A=%h B=%h Z=%b W=%b A3=%h Z3=%b B3=%h W3=%b want A=%h B=%h Z=%b W=%b A3=0000 Z3=1 B3=%h W3=%b",
                        x.name, OutA, OutB, OutAZero, Wrap, OutA3, OutAZero3, OutB3, Wrap3,
                        x.exp_a, x.exp_b, (x.exp_a == 16'h0000), x.exp_wrap, x.exp_b3, x.exp_wrap[2:0]);
            end else begin
               $display("ok   %s: A=%h B=%h Z=%b W=%b B3=%h", x.name, OutA, OutB, OutAZero, Wrap, OutB3);
            end
         end
      end
   end

   initial begin
      #100000;
      if (!done) begin
         $display("FAIL timeout: run did not complete, %0d expectations pending", sb.size());
         $fatal(1, "timeout");
      end
   end

   initial begin
      Reset = 1'b1; E = 4'h0; FunSel = FS_HOLD; I = 16'h0000; OutASel = 2'd0; OutBSel = 2'd1;

      //  rst  E     FunSel      I        A  B  name           expA     expB     wrap
      txn(1'b1, 4'hF, FS_INC,     16'h0000, 0, 1, "reset",        16'h0000, 16'h0000, 4'b0000);
      txn(1'b0, 4'h1, FS_LOAD,    16'hBEEF, 0, 1, "load_r0",      16'hBEEF, 16'h0000, 4'b0000);
      txn(1'b0, 4'h0, FS_LOAD,    16'h1111, 2, 3, "hold_r2_r3",   16'h0000, 16'h0000, 4'b0000);
      txn(1'b0, 4'h2, FS_DEC,     16'h0000, 1, 0, "dec_wrap_r1",  16'hFFFF, 16'hBEEF, 4'b0010);
      txn(1'b0, 4'h2, FS_INC,     16'h0000, 1, 0, "inc_wrap_r1",  16'h0000, 16'hBEEF, 4'b0010);
      txn(1'b0, 4'h2, FS_CLEAR,   16'h0000, 1, 0, "clear_r1",     16'h0000, 16'hBEEF, 4'b0000);
      txn(1'b0, 4'h4, FS_LOAD,    16'h1234, 2, 1, "load_r2",      16'h1234, 16'h0000, 4'b0000);
      txn(1'b0, 4'h4, FS_LO_LOAD, 16'h00AB, 2, 1, "lo_load",      16'h12AB, 16'h0000, 4'b0000);
      txn(1'b0, 4'h4, FS_LOAD,    16'h1234, 2, 1, "reload_r2",    16'h1234, 16'h0000, 4'b0000);
      txn(1'b0, 4'h4, FS_HI_LOAD, 16'h00AB, 2, 1, "hi_load",      16'hAB34, 16'h0000, 4'b0000);
      txn(1'b0, 4'h4, FS_LO_ZEXT, 16'hFF5C, 2, 1, "lo_zext",      16'h005C, 16'h0000, 4'b0000);
      txn(1'b0, 4'h4, FS_LO_SEXT, 16'h0080, 2, 1, "sext_neg",     16'hFF80, 16'h0000, 4'b0000);
      txn(1'b0, 4'h4, FS_LO_SEXT, 16'h007F, 2, 1, "sext_pos",     16'h007F, 16'h0000, 4'b0000);
      txn(1'b0, 4'h8, FS_LOAD,    16'h8001, 3, 2, "load_r3",      16'h8001, 16'h007F, 4'b0000);
      txn(1'b0, 4'h8, FS_SLL,     16'h0000, 3, 2, "sll",          16'h0002, 16'h007F, 4'b0000);
      txn(1'b0, 4'h8, FS_LOAD,    16'h8001, 3, 2, "load_r3",      16'h8001, 16'h007F, 4'b0000);
      txn(1'b0, 4'h8, FS_SRL,     16'h0000, 3, 2, "srl",          16'h4000, 16'h007F, 4'b0000);
      txn(1'b0, 4'h8, FS_LOAD,    16'h8001, 3, 2, "load_r3",      16'h8001, 16'h007F, 4'b0000);
      txn(1'b0, 4'h8, FS_SRA,     16'h0000, 3, 2, "sra",          16'hC000, 16'h007F, 4'b0000);
      txn(1'b0, 4'h8, FS_LOAD,    16'h8001, 3, 2, "load_r3",      16'h8001, 16'h007F, 4'b0000);
      txn(1'b0, 4'h8, FS_ROL,     16'h0000, 3, 2, "rol",          16'h0003, 16'h007F, 4'b0000);
      txn(1'b0, 4'h8, FS_LOAD,    16'h8001, 3, 2, "load_r3",      16'h8001, 16'h007F, 4'b0000);
      txn(1'b0, 4'h8, FS_ROR,     16'h0000, 3, 2, "ror",          16'hC000, 16'h007F, 4'b0000);
      txn(1'b0, 4'h8, FS_SRA,     16'h0000, 3, 2, "sra_neg",      16'hE000, 16'h007F, 4'b0000);
      txn(1'b0, 4'h1, FS_LOAD,    16'hFFFF, 0, 3, "load_r0_ones", 16'hFFFF, 16'hE000, 4'b0000);
      txn(1'b0, 4'h1, FS_SAT_INC, 16'h0000, 0, 3, "sat_inc_top",  16'hFFFF, 16'hE000, 4'b0000);
      txn(1'b0, 4'h1, FS_CLEAR,   16'h0000, 0, 3, "clear_r0",     16'h0000, 16'hE000, 4'b0000);
      txn(1'b0, 4'h1, FS_SAT_DEC, 16'h0000, 0, 3, "sat_dec_bot",  16'h0000, 16'hE000, 4'b0000);
      txn(1'b0, 4'h1, FS_SAT_INC, 16'h0000, 0, 3, "sat_inc",      16'h0001, 16'hE000, 4'b0000);
      txn(1'b0, 4'h1, FS_HOLD,    16'h7777, 0, 3, "fs_hold",      16'h0001, 16'hE000, 4'b0000);
      txn(1'b0, 4'h1, FS_SAT_DEC, 16'h0000, 0, 3, "sat_dec",      16'h0000, 16'hE000, 4'b0000);
      txn(1'b0, 4'h1, FS_DEC,     16'h0000, 0, 3, "dec_wrap_r0",  16'hFFFF, 16'hE000, 4'b0001);
      txn(1'b0, 4'hF, FS_LOAD,    16'h5A5A, 2, 2, "multi_load",   16'h5A5A, 16'h5A5A, 4'b0001);
      txn(1'b0, 4'hF, FS_INC,     16'h0000, 0, 3, "multi_inc",    16'h5A5B, 16'h5A5B, 4'b0001);
      txn(1'b1, 4'hF, FS_INC,     16'h0000, 2, 0, "reset_prio",   16'h0000, 16'h0000, 4'b0000);
      txn(1'b0, 4'h0, FS_HOLD,    16'h0000, 1, 2, "idle",         16'h0000, 16'h0000, 4'b0000);

      repeat (3) @(negedge Clock);
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d expectations left, want 0", sb.size());
      end
      done = 1'b1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
